lock_controller: RTL and testbench
==================================

Name: lock_controller

Overview:
- Sequences the door-lock resource driven by the serial pattern detector.
- Consumes the detector's one-cycle match pulse and the keypad's end-of-attempt strobe.
- Counts failed attempts, imposes a timed lockout after MAX_FAIL failures, and holds the lock open for a fixed time or until the door closes.
- Clears the detector between attempts.

Parameters:
- MAX_FAIL, 3, consecutive failed attempts that trigger lockout (>=1)
- OPEN_CYCLES, 8, minimum cycles door_open stays high after a successful match (>=1)
- LOCKOUT_CYCLES, 16, cycles spent in lockout (>=1)
- CW, $clog2(MAX_FAIL+1), fail counter width (derived, not overridden)
- TW, $clog2(max(OPEN_CYCLES,LOCKOUT_CYCLES)+1), timer width (derived)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- match  input  1  one-cycle pulse from pattern detector: correct code seen
- attempt_end  input  1  one-cycle pulse from keypad: current entry attempt finished
- door_closed  input  1  door sensor, 1 = closed (already synchronised upstream)
- door_open  output  1  lock actuator, 1 = unlocked
- ajar  output  1  open time expired but door not yet closed
- locked_out  output  1  lockout active, inputs ignored
- det_clr  output  1  synchronous clear to pattern detector
- fail_cnt  output  CW  current consecutive failure count

Behaviour:
- States: LOCKED, OPEN, WAIT_CLOSE, LOCKOUT. State, timer, fail_cnt and det_clr are registers. door_open, ajar and locked_out are Moore decodes of the state register.
- Reset (asynchronous, reset=0):
  - state=LOCKED, timer=0, fail_cnt=0, det_clr=0.
  - Therefore door_open=0, ajar=0, locked_out=0.
  - Reset mid-operation (any state) returns here immediately; no pending timer survives.
- LOCKED:
  - match=1 (with or without attempt_end): go to OPEN, timer<=OPEN_CYCLES-1, fail_cnt<=0. Match wins over a simultaneous attempt_end, which is not counted as a failure.
  - attempt_end=1, match=0, fail_cnt+1<MAX_FAIL: fail_cnt<=fail_cnt+1, stay LOCKED, det_clr<=1 for exactly the next cycle.
  - attempt_end=1, match=0, fail_cnt+1==MAX_FAIL: go to LOCKOUT, timer<=LOCKOUT_CYCLES-1, fail_cnt<=MAX_FAIL (held, visible during lockout).
  - Otherwise hold.
- OPEN:
  - door_open=1.
  - timer!=0: timer<=timer-1.
  - timer==0: go to LOCKED if door_closed=1, else go to WAIT_CLOSE.
  - door_open is therefore high for exactly OPEN_CYCLES cycles when the door is closed at expiry.
- WAIT_CLOSE:
  - door_open=1, ajar=1.
  - door_closed=1: go to LOCKED. No timeout.
- LOCKOUT:
  - locked_out=1, door_open=0.
  - match and attempt_end are ignored.
  - timer!=0: decrement.
  - timer==0: go to LOCKED, fail_cnt<=0. Lockout lasts exactly LOCKOUT_CYCLES cycles.
- det_clr:
  - Registered.
  - High in every cycle where state!=LOCKED.
  - Also high for one cycle after a counted failure.
  - Low otherwise, so the detector starts fresh on each attempt and on re-entry to LOCKED.
- match and attempt_end are ignored in OPEN and WAIT_CLOSE. A match during OPEN does not restart the timer.
- fail_cnt saturates at MAX_FAIL. It cannot wrap.
- Timers count down only. No wrap past 0 because the exit happens at 0.

Test Plan:
- Reset and idle:
  - Stimulus: assert reset=0 mid-cycle.
  - Response: all outputs 0 and fail_cnt=0 without waiting for a clock edge.
  - Stimulus: release reset, idle 5 cycles.
  - Response: outputs stay 0.
- Success path:
  - Stimulus: match pulse at edge t, door_closed=1.
  - Response: door_open=1 for cycles t+1..t+8 (8 cycles), 0 at t+9, det_clr high over the same window.
- Lockout:
  - Stimulus: three attempt_end pulses without match.
  - Response: fail_cnt goes 1, 2 with a one-cycle det_clr after each; on the third, locked_out=1 for exactly 16 cycles and fail_cnt=3.
  - Stimulus: match pulses during lockout.
  - Response: ignored, door_open stays 0. After lockout, fail_cnt=0.
- Door held open:
  - Stimulus: match with door_closed=0 for 20 cycles.
  - Response: door_open=1 for 8 cycles with ajar=0, then ajar=1 and door_open=1 until door_closed rises, then LOCKED with both 0 the next cycle.
- Simultaneous events:
  - Stimulus: fail_cnt=2, then match and attempt_end in the same cycle.
  - Response: OPEN entered, fail_cnt=0, no lockout.
  - Stimulus: fail_cnt=1, then attempt_end alone.
  - Response: fail_cnt=2.
- Reset mid-lockout:
  - Stimulus: reset=0 at lockout cycle 5.
  - Response: immediately LOCKED, locked_out=0, fail_cnt=0.
  - Stimulus: a subsequent single match.
  - Response: opens normally.

Source files
------------

// File: rtl/lock_controller.sv
// Door-lock sequencer: opens on a detector match, counts failed attempts,
// imposes a timed lockout and keeps the pattern detector cleared between attempts.
module lock_controller #(
  parameter  int MAX_FAIL       = 3,
  parameter  int OPEN_CYCLES    = 8,
  parameter  int LOCKOUT_CYCLES = 16,
  localparam int CW             = $clog2(MAX_FAIL + 1),
  localparam int TW             = $clog2(((OPEN_CYCLES > LOCKOUT_CYCLES) ?
                                          OPEN_CYCLES : LOCKOUT_CYCLES) + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          match,
  input  logic          attempt_end,
  input  logic          door_closed,
  output logic          door_open,
  output logic          ajar,
  output logic          locked_out,
  output logic          det_clr,
  output logic [CW-1:0] fail_cnt
);

  typedef enum logic [1:0] {
    LOCKED     = 2'd0,
    OPEN       = 2'd1,
    WAIT_CLOSE = 2'd2,
    LOCKOUT    = 2'd3
  } state_t;

  state_t        state_r;
  logic [TW-1:0] timer_r;
  logic [CW-1:0] fail_cnt_r;
  logic          det_clr_r;
  logic          last_fail_s;

  // This failure is the one that reaches the limit and starts lockout.
  assign last_fail_s = ({1'b0, fail_cnt_r} + {{CW{1'b0}}, 1'b1}) >= (CW+1)'(MAX_FAIL);

  // Main sequencer: state, countdown timer, failure count and detector clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= LOCKED;
      timer_r    <= {TW{1'b0}};
      fail_cnt_r <= {CW{1'b0}};
      det_clr_r  <= 1'b0;
    end else begin
      case (state_r)
        LOCKED: begin
          if (match) begin
            state_r    <= OPEN;
            timer_r    <= TW'(OPEN_CYCLES - 1);
            fail_cnt_r <= {CW{1'b0}};
            det_clr_r  <= 1'b1;
          end else if (attempt_end) begin
            det_clr_r <= 1'b1;
            if (last_fail_s) begin
              state_r    <= LOCKOUT;
              timer_r    <= TW'(LOCKOUT_CYCLES - 1);
              fail_cnt_r <= CW'(MAX_FAIL);
            end else begin
              fail_cnt_r <= fail_cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
          end else begin
            det_clr_r <= 1'b0;
          end
        end
        OPEN: begin
          // Exit decision is taken on the last open cycle, using the door sensor then.
          if (timer_r != {TW{1'b0}}) begin
            timer_r   <= timer_r - {{(TW-1){1'b0}}, 1'b1};
            det_clr_r <= 1'b1;
          end else if (door_closed) begin
            state_r   <= LOCKED;
            det_clr_r <= 1'b0;
          end else begin
            state_r   <= WAIT_CLOSE;
            det_clr_r <= 1'b1;
          end
        end
        WAIT_CLOSE: begin
          if (door_closed) begin
            state_r   <= LOCKED;
            det_clr_r <= 1'b0;
          end else begin
            det_clr_r <= 1'b1;
          end
        end
        LOCKOUT: begin
          if (timer_r != {TW{1'b0}}) begin
            timer_r   <= timer_r - {{(TW-1){1'b0}}, 1'b1};
            det_clr_r <= 1'b1;
          end else begin
            state_r    <= LOCKED;
            fail_cnt_r <= {CW{1'b0}};
            det_clr_r  <= 1'b0;
          end
        end
        default: begin
          state_r    <= LOCKED;
          timer_r    <= {TW{1'b0}};
          fail_cnt_r <= {CW{1'b0}};
          det_clr_r  <= 1'b0;
        end
      endcase
    end
  end

  assign door_open  = (state_r == OPEN) || (state_r == WAIT_CLOSE);
  assign ajar       = (state_r == WAIT_CLOSE);
  assign locked_out = (state_r == LOCKOUT);
  assign det_clr    = det_clr_r;
  assign fail_cnt   = fail_cnt_r;

endmodule

// File: tb/tb_lock_controller.sv
// Bench for lock_controller: fixed vector table, hand-written corner sequences,
// then random traffic against a countdown-based reference model.
module tb_lock_controller;

  localparam int MAX_FAIL = 3;
  localparam int OPEN_C   = 8;
  localparam int LOCK_C   = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       match = 1'b0;
  logic       attempt_end = 1'b0;
  logic       door_closed = 1'b1;
  logic       door_open, ajar, locked_out, det_clr;
  logic [1:0] fail_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  lock_controller #(.MAX_FAIL(MAX_FAIL), .OPEN_CYCLES(OPEN_C), .LOCKOUT_CYCLES(LOCK_C)) dut (
    .clk(clk), .reset(reset), .match(match), .attempt_end(attempt_end),
    .door_closed(door_closed), .door_open(door_open), .ajar(ajar),
    .locked_out(locked_out), .det_clr(det_clr), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: remaining open/lockout cycles, ajar flag and failure count.
  int m_open_left, m_lock_left, m_fails;
  bit m_ajar, m_det;

  function automatic void model_reset();
    m_open_left = 0; m_lock_left = 0; m_fails = 0; m_ajar = 0; m_det = 0;
  endfunction

  function automatic void model_edge(input bit m, input bit a, input bit dc);
    bit counted = 0;
    if (m_lock_left > 0) begin
      m_lock_left--;
      if (m_lock_left == 0) m_fails = 0;
    end else if (m_open_left > 0) begin
      m_open_left--;
      if (m_open_left == 0 && !dc) m_ajar = 1;
    end else if (m_ajar) begin
      if (dc) m_ajar = 0;
    end else if (m) begin
      m_open_left = OPEN_C;
      m_fails = 0;
    end else if (a) begin
      m_fails++;
      if (m_fails >= MAX_FAIL) m_lock_left = LOCK_C;
      else counted = 1;
    end
    m_det = counted || (m_open_left > 0) || m_ajar || (m_lock_left > 0);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic chk_all(input string name, input bit op, input bit aj, input bit lo,
                         input bit dt, input int fc);
    chk({name, ".door_open"},  32'(door_open),  32'(op));
    chk({name, ".ajar"},       32'(ajar),       32'(aj));
    chk({name, ".locked_out"}, 32'(locked_out), 32'(lo));
    chk({name, ".det_clr"},    32'(det_clr),    32'(dt));
    chk({name, ".fail_cnt"},   32'(fail_cnt),   32'(fc));
  endtask

  // Apply inputs from a falling edge, clock once, advance model, return on the next falling edge.
  task automatic step(input bit m, input bit a, input bit dc);
    match = m; attempt_end = a; door_closed = dc;
    @(posedge clk);
    model_edge(m, a, dc);
    @(negedge clk);
  endtask

  task automatic reset_mid_cycle();
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    model_reset();
  endtask

  task automatic release_reset();
    @(negedge clk);
    match = 1'b0; attempt_end = 1'b0; door_closed = 1'b1;
    reset = 1'b1;
  endtask

  typedef struct {
    bit m, a, dc;
    bit op, aj, lo, dt;
    int fc;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input bit m, input bit a, input bit dc, input bit op,
                              input bit aj, input bit lo, input bit dt, input int fc);
    vec_t v;
    v.m = m; v.a = a; v.dc = dc; v.op = op; v.aj = aj; v.lo = lo; v.dt = dt; v.fc = fc;
    vecs.push_back(v);
  endfunction

  initial begin
    int k;
    bit rdc;
    model_reset();

    // Table: idle, two counted failures, simultaneous match+attempt, full open window.
    for (int i = 0; i < 5; i++) add(0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 0, 1, 1);
    add(0, 0, 1, 0, 0, 0, 0, 1);
    add(0, 1, 1, 0, 0, 0, 1, 2);
    add(0, 0, 1, 0, 0, 0, 0, 2);
    add(1, 1, 1, 1, 0, 0, 1, 0);
    add(0, 0, 1, 1, 0, 0, 1, 0);
    add(1, 0, 1, 1, 0, 0, 1, 0);
    add(0, 1, 1, 1, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 1, 1, 0, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);

    // Asynchronous reset seen without a clock edge.
    reset_mid_cycle();
    chk_all("reset_async", 0, 0, 0, 0, 0);
    release_reset();
    @(negedge clk);

    foreach (vecs[i]) begin
      step(vecs[i].m, vecs[i].a, vecs[i].dc);
      chk_all($sformatf("vec%0d", i), vecs[i].op, vecs[i].aj, vecs[i].lo, vecs[i].dt, vecs[i].fc);
    end

    // Three failures lead to lockout; matches inside lockout are ignored.
    step(0, 1, 1); chk_all("lk_fail1", 0, 0, 0, 1, 1);
    step(0, 0, 1); chk_all("lk_gap1",  0, 0, 0, 0, 1);
    step(0, 1, 1); chk_all("lk_fail2", 0, 0, 0, 1, 2);
    step(0, 0, 1); chk_all("lk_gap2",  0, 0, 0, 0, 2);
    step(0, 1, 1); chk_all("lk_enter", 0, 0, 1, 1, 3);
    k = 1;
    while (k < 40) begin
      step((k % 3) == 0, (k % 5) == 0, 1);
      if (!locked_out) break;
      if (door_open || fail_cnt != 2'd3) chk("lk_hold", {30'd0, door_open, 1'b0}, 32'(0));
      k++;
    end
    chk("lk_length", 32'(k), 32'(LOCK_C));
    chk_all("lk_exit", 0, 0, 0, 0, 0);

    // Door held open: 8 open cycles, then ajar until the door closes.
    step(1, 0, 0);
    k = 0;
    while (door_open && !ajar && k < 30) begin
      k++;
      step(0, 0, 0);
    end
    chk("ajar_open_len", 32'(k), 32'(OPEN_C));
    chk_all("ajar_enter", 1, 1, 0, 1, 0);
    for (int i = 0; i < 12; i++) step(1, 1, 0);
    chk_all("ajar_hold", 1, 1, 0, 1, 0);
    step(0, 0, 1);
    chk_all("ajar_close", 0, 0, 0, 0, 0);

    // Reset during lockout, then a normal open.
    step(0, 1, 1); step(0, 1, 1); step(0, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 1);
    chk_all("rl_before", 0, 0, 1, 1, 3);
    reset_mid_cycle();
    chk_all("rl_async", 0, 0, 0, 0, 0);
    release_reset();
    @(negedge clk);
    chk_all("rl_idle", 0, 0, 0, 0, 0);
    step(1, 0, 1);
    chk_all("rl_open", 1, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1);
    chk_all("rl_relock", 0, 0, 0, 0, 0);

    // Random traffic against the reference model.
    reset_mid_cycle();
    release_reset();
    @(negedge clk);
    rdc = 1;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(7) == 0) rdc = ~rdc;
      step($urandom_range(11) == 0, $urandom_range(4) == 0, rdc);
      chk_all($sformatf("rnd%0d", i), (m_open_left > 0) || m_ajar, m_ajar,
              m_lock_left > 0, m_det, m_fails);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
